// File: rtl/control_pkg.sv
// Shared definitions for the one-wire switch-state link.
// Used by both the transmitter and the receiver.
package control_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int   FRAME_DATA_BITS = 4;
  localparam logic LINE_IDLE       = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with async active-low reset.
// Reset value is a parameter so an idle-high line stays idle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/control_rx.sv
// Serial receiver for the switch-state link: start, 4 data LSB
// first, stop. Latches good frames, flags bad stop bits.
module control_rx
  import control_pkg::*;
#(
  parameter int BIT_TICKS = 434
) (
  input  logic                       sysclk,
  input  logic                       rst_n,
  input  logic                       in,
  output logic [FRAME_DATA_BITS-1:0] sw_out,
  output logic                       valid,
  output logic                       frame_err,
  output logic                       busy
);

  localparam int CW = $clog2(BIT_TICKS);
  localparam int IW = $clog2(FRAME_DATA_BITS);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [IW-1:0] idx_t;
  typedef logic [FRAME_DATA_BITS-1:0] data_t;

  localparam cnt_t HALF_LOAD = cnt_t'(BIT_TICKS / 2 - 1);
  localparam cnt_t FULL_LOAD = cnt_t'(BIT_TICKS - 1);
  localparam idx_t IDX_LAST  = idx_t'(FRAME_DATA_BITS - 1);

  logic      in_s;
  rx_state_t state, state_d;
  cnt_t      cnt, cnt_d;
  idx_t      idx, idx_d;
  data_t     shreg, shreg_d;
  data_t     sw_d;
  logic      valid_d, err_d;
  logic      armed;
  logic [1:0] flush;
  logic      tick;

  sync_2ff #(
    .RST_VAL(LINE_IDLE)
  ) u_sync (
    .clk  (sysclk),
    .rst_n(rst_n),
    .d    (in),
    .q    (in_s)
  );

  assign tick = (cnt == '0);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shreg_d = shreg;
    sw_d    = sw_out;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && in_s != LINE_IDLE) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt - cnt_t'(1);
        end else if (in_s == LINE_IDLE) begin
          state_d = IDLE;
          cnt_d   = FULL_LOAD;
        end else begin
          state_d = DATA;
          cnt_d   = FULL_LOAD;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt - cnt_t'(1);
        end else begin
          shreg_d = {in_s, shreg[FRAME_DATA_BITS-1:1]};
          cnt_d   = FULL_LOAD;
          idx_d   = idx + idx_t'(1);
          if (idx == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt - cnt_t'(1);
        end else if (in_s == LINE_IDLE) begin
          state_d = IDLE;
          cnt_d   = FULL_LOAD;
          sw_d    = shreg;
          valid_d = 1'b1;
        end else begin
          state_d = BREAK;
          cnt_d   = FULL_LOAD;
          err_d   = 1'b1;
        end
      end
      BREAK: begin
        if (in_s == LINE_IDLE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      sw_out    <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      flush     <= '0;
      armed     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      shreg     <= shreg_d;
      sw_out    <= sw_d;
      valid     <= valid_d;
      frame_err <= err_d;
      busy      <= (state_d != IDLE);
      // ignore the synchronizer's reset value until real data reaches it
      flush     <= {flush[0], 1'b1};
      armed     <= armed | (flush[1] & in_s);
    end
  end

endmodule

// File: doc/control_rx.md
# control_rx

Serial receiver for the one-wire switch-state link driven by the `control` transmitter. It recovers the 4-bit switch frame (sw1..sw4) from the serial line and presents it as a latched parallel word with a one-cycle valid strobe. It also flags malformed frames. It sits at the far end of the link, on the same `sysclk` domain as the transmitter, and is the checker/consumer for the transmitter output.

## Interface
- `BIT_TICKS`, default 434: sysclk cycles per bit on the line; must be ≥ 4.
- `sysclk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in` input 1: serial line; idles high; asynchronous to frame timing.
- `sw_out` output 4: last good frame; bit 0 = sw1 … bit 3 = sw4.
- `valid` output 1: one-cycle pulse when `sw_out` has just been updated.
- `frame_err` output 1: one-cycle pulse on bad stop bit.
- `busy` output 1: high from start-edge detection until return to IDLE.

## Operation
- Frame format, fixed: 1 start bit (low), 4 data bits LSB first (sw1 first), 1 stop bit (high). Each bit lasts `BIT_TICKS` cycles.
- `in` passes through a 2-flop synchronizer to give `in_s`. All decisions use `in_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: wait for `in_s` = 0, then go to START and load the tick counter.
- START: count `BIT_TICKS/2` cycles (integer divide) to reach mid start bit, then sample.
  - Sample 1 → false start; return to IDLE with no pulse.
  - Sample 0 → go to DATA with bit index 0.
- DATA: sample every `BIT_TICKS` cycles and shift into a 4-bit register LSB first. After index 3, go to STOP.
- STOP: sample `BIT_TICKS` cycles after the last data sample.
  - Sample 1 → copy the shift register to `sw_out`, pulse `valid`, return to IDLE.
  - Sample 0 → pulse `frame_err`, keep `sw_out` unchanged, go to BREAK.
- BREAK: stay until `in_s` = 1, then go to IDLE. A low line held indefinitely produces exactly one `frame_err`.
- Tick counter: width `$clog2(BIT_TICKS)`. It counts down to 0 and is reloaded on every sample; it never wraps silently.
- Identical back-to-back frames each produce their own `valid` pulse. There is no duplicate suppression.

## Timing
- Reset values: `sw_out` = 4'b0000, `valid` = 0, `frame_err` = 0, `busy` = 0. FSM in IDLE, counter 0, shift register 0.
- Reset is asynchronous. Assertion mid-frame aborts immediately with no pulse.
- After reset deassertion, the FSM stays in IDLE until the synchronized line has been seen high at least once. A line held low through reset therefore produces no frame and no error.
- Synchronizer latency: 2 cycles from an `in` edge to `in_s`.
- Start edge to START sample: `BIT_TICKS/2` cycles after `in_s` falls.
- Data sample n (n = 0..3): START sample + (n+1)·`BIT_TICKS` cycles.
- Stop sample: START sample + 5·`BIT_TICKS` cycles.
- `valid` / `frame_err` are registered and assert the cycle after the stop sample. `sw_out` changes on the same edge that `valid` rises.
- `busy` rises the cycle after the IDLE→START transition. It falls in the same cycle `valid` pulses, or when leaving BREAK.
- A new start edge is accepted in the first IDLE cycle after the stop sample. This gives a minimum inter-frame gap of half a stop bit.
- `valid` and `frame_err` are never high in the same cycle.

## Structure
- Package `control_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, STOP, BREAK)
  - `FRAME_DATA_BITS` = 4
  - `LINE_IDLE` = 1'b1
  - the transmitter reuses `FRAME_DATA_BITS` and `LINE_IDLE`.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with async active-low reset. It resets to 1 so the idle line does not look like a start.
- Everything else (FSM, tick counter, bit index, shift register, output registers) lives in `control_rx`.

## Test plan
Bench uses `BIT_TICKS` = 16 and drives an ideal frame generator.
- Reset, line idle high for 100 cycles → all outputs 0, no `valid`.
- Frame 4'b0001 → `sw_out` = 4'b0001 with one `valid` pulse exactly 2 + 8 + 80 + 1 cycles after the start edge; `busy` high throughout.
- Frames 4'b0111, 4'b1111, 4'b1111 back-to-back with minimum gap → three `valid` pulses; final `sw_out` = 4'b1111.
- Frame 4'b1010 with stop bit forced low and then held low for 200 cycles → single `frame_err`, `sw_out` keeps its previous value, `busy` stays high until the line returns high.
- 5-cycle low glitch on the idle line → false start; no `valid`, no `frame_err`; `busy` returns to 0 within 10 cycles.
- `rst_n` pulsed low mid-DATA of frame 4'b1100 → outputs at reset values, no pulse for the aborted frame; the next clean frame 4'b0011 decodes correctly.
